// File: rtl/bp_pkg.sv
// Shared types and helpers for the BHT branch direction predictor.
// Counter encoding: bit 1 is the predicted direction (1 = taken).
package bp_pkg;

   typedef logic [1:0] bht_ctr_t;

   localparam bht_ctr_t SNT = 2'd0;
   localparam bht_ctr_t WNT = 2'd1;
   localparam bht_ctr_t WT  = 2'd2;
   localparam bht_ctr_t ST  = 2'd3;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } bp_state_t;

   function automatic bht_ctr_t sat_update(bht_ctr_t v, logic taken);
      if (taken)
         return (v == ST) ? ST : bht_ctr_t'(v + 2'd1);
      else
         return (v == SNT) ? SNT : bht_ctr_t'(v - 2'd1);
   endfunction

endpackage

// File: rtl/bht_init_seq.sv
// Init sequencer for the BHT: walks every entry after reset or clear_tbl,
// and selects the table write port between the init walk and branch updates.
module bht_init_seq
   import bp_pkg::*;
#(
   parameter int IDX_BITS = 6
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clear_tbl,
   input  logic                update_en,
   input  logic [IDX_BITS-1:0] upd_idx,
   output logic                busy,
   output logic                tbl_we,
   output logic                tbl_sel_init,
   output logic [IDX_BITS-1:0] tbl_idx,
   output logic                state_dbg
);

   localparam logic [IDX_BITS-1:0] IDX_LAST = '1;

   bp_state_t           state;
   logic [IDX_BITS-1:0] init_idx;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= INIT;
         init_idx <= '0;
      end else begin
         case (state)
            INIT: begin
               if (clear_tbl) begin
                  init_idx <= '0;
               end else if (init_idx == IDX_LAST) begin
                  state    <= RUN;
                  init_idx <= '0;
               end else begin
                  init_idx <= init_idx + IDX_BITS'(1);
               end
            end
            RUN: begin
               if (clear_tbl) begin
                  state    <= INIT;
                  init_idx <= '0;
               end
            end
            default: begin
               state    <= INIT;
               init_idx <= '0;
            end
         endcase
      end
   end

   // While walking, the init write owns the port and branch updates are dropped.
   always_comb begin
      busy         = (state == INIT);
      tbl_sel_init = busy;
      tbl_we       = busy | update_en;
      tbl_idx      = busy ? init_idx : upd_idx;
      state_dbg    = state;
   end

endmodule

// File: rtl/bht_predictor.sv
// Dynamic branch direction predictor: 2-bit saturating BHT indexed by fetch PC,
// F->D prediction pipeline register, and saturating branch/mispredict statistics.
module bht_predictor
   import bp_pkg::*;
#(
   parameter int       IDX_BITS = 6,
   parameter bht_ctr_t INIT_VAL = WNT,
   parameter int       STAT_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       pc_f,
   input  logic              stall_d,
   input  logic              reset_d,
   input  logic              update_en,
   input  logic              pc_src_d,
   input  logic              mispred_d,
   input  logic              clear_tbl,
   output logic              pred_f,
   output logic              pred_d,
   output logic              busy,
   output logic [STAT_W-1:0] branch_cnt,
   output logic [STAT_W-1:0] mispred_cnt
);

   localparam int                NUM_ENT  = 1 << IDX_BITS;
   localparam logic [STAT_W-1:0] STAT_MAX = '1;

   bht_ctr_t            bht [NUM_ENT];
   logic [IDX_BITS-1:0] idx_f;
   logic [IDX_BITS-1:0] idx_d;
   logic [IDX_BITS-1:0] tbl_idx;
   logic                tbl_we;
   logic                tbl_sel_init;
   logic                state_dbg;
   logic                unused_bits;

   assign idx_f       = pc_f[IDX_BITS+1:2];
   assign unused_bits = ^{pc_f[31:IDX_BITS+2], pc_f[1:0], state_dbg};

   bht_init_seq #(.IDX_BITS(IDX_BITS)) u_seq (
      .clk          (clk),
      .reset        (reset),
      .clear_tbl    (clear_tbl),
      .update_en    (update_en),
      .upd_idx      (idx_d),
      .busy         (busy),
      .tbl_we       (tbl_we),
      .tbl_sel_init (tbl_sel_init),
      .tbl_idx      (tbl_idx),
      .state_dbg    (state_dbg)
   );

   // No read bypass: a same-cycle update to idx_f is visible only after the edge.
   assign pred_f = ~busy & bht[idx_f][1];

   always_ff @(posedge clk) begin
      if (tbl_we)
         bht[tbl_idx] <= tbl_sel_init ? INIT_VAL : sat_update(bht[idx_d], pc_src_d);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pred_d <= 1'b0;
         idx_d  <= '0;
      end else if (reset_d) begin
         pred_d <= 1'b0;
         idx_d  <= '0;
      end else if (!stall_d) begin
         pred_d <= pred_f;
         idx_d  <= idx_f;
      end
   end

   // update_en qualifies pc_src_d/mispred_d for exactly one cycle; there is no backpressure.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         branch_cnt  <= '0;
         mispred_cnt <= '0;
      end else if (!busy) begin
         if (clear_tbl) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
         end else if (update_en) begin
            if (branch_cnt != STAT_MAX)
               branch_cnt <= branch_cnt + STAT_W'(1);
            if (mispred_d && (mispred_cnt != STAT_MAX))
               mispred_cnt <= mispred_cnt + STAT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_bht_predictor.sv
// Directed, table-driven bench for bht_predictor; a second instance with
// 4-bit statistics shares the stimulus to exercise counter saturation.
module tb_bht_predictor;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] pc_f = '0;
   logic        stall_d = 1'b0;
   logic        reset_d = 1'b0;
   logic        update_en = 1'b0;
   logic        pc_src_d = 1'b0;
   logic        mispred_d = 1'b0;
   logic        clear_tbl = 1'b0;
   logic        pred_f, pred_d, busy;
   logic [15:0] branch_cnt, mispred_cnt;
   logic        pred_f4, pred_d4, busy4;
   logic [3:0]  branch_cnt4, mispred_cnt4;

   int n_chk  = 0;
   int n_pass = 0;
   int exp_br = 0;
   int exp_mis = 0;
   int cyc;
   int pf_bad;

   typedef struct {
      logic       upd;
      logic       taken;
      logic       mis;
      logic [1:0] exp_ctr;
      logic       exp_pf;
      logic       exp_pd;
   } vec_t;

   vec_t vecs [8];

   bht_predictor dut (
      .clk(clk), .reset(reset), .pc_f(pc_f), .stall_d(stall_d), .reset_d(reset_d),
      .update_en(update_en), .pc_src_d(pc_src_d), .mispred_d(mispred_d),
      .clear_tbl(clear_tbl), .pred_f(pred_f), .pred_d(pred_d), .busy(busy),
      .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
   );

   bht_predictor #(.STAT_W(4)) dut4 (
      .clk(clk), .reset(reset), .pc_f(pc_f), .stall_d(stall_d), .reset_d(reset_d),
      .update_en(update_en), .pc_src_d(pc_src_d), .mispred_d(mispred_d),
      .clear_tbl(clear_tbl), .pred_f(pred_f4), .pred_d(pred_d4), .busy(busy4),
      .branch_cnt(branch_cnt4), .mispred_cnt(mispred_cnt4)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic int sat4(input int v);
      return (v > 15) ? 15 : v;
   endfunction

   task automatic chk_stats(input string tag);
      chk({tag, " branch_cnt"},   32'(branch_cnt),   exp_br);
      chk({tag, " mispred_cnt"},  32'(mispred_cnt),  exp_mis);
      chk({tag, " branch_cnt4"},  32'(branch_cnt4),  sat4(exp_br));
      chk({tag, " mispred_cnt4"}, 32'(mispred_cnt4), sat4(exp_mis));
   endtask

   task automatic chk_tbl(input string tag);
      for (int i = 0; i < 64; i++)
         chk($sformatf("%s entry %0d", tag, i), 32'(dut.bht[i]), 32'd1);
   endtask

   // Count busy cycles from the current sample point; optionally inject a
   // branch update while the walk is in progress.
   task automatic run_init(input bit inject, output int n);
      n = 0;
      pf_bad = 0;
      while (busy && n < 200) begin
         if (inject && n == 30) begin
            update_en = 1'b1; pc_src_d = 1'b1; mispred_d = 1'b1;
         end else begin
            update_en = 1'b0; mispred_d = 1'b0;
         end
         if (!inject) pc_f = $urandom_range(0, 255) << 2;
         #1;
         if (pred_f !== 1'b0) pf_bad++;
         n++;
         step();
      end
      update_en = 1'b0; mispred_d = 1'b0; pc_src_d = 1'b0;
   endtask

   initial begin
      vecs[0] = '{1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0};
      vecs[1] = '{1'b1, 1'b1, 1'b1, 2'b11, 1'b1, 1'b1};
      vecs[2] = '{1'b1, 1'b1, 1'b0, 2'b11, 1'b1, 1'b1};
      vecs[3] = '{1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 1'b1};
      vecs[4] = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1};
      vecs[5] = '{1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0};
      vecs[6] = '{1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
      vecs[7] = '{1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0};

      // reset state
      #3 reset = 1'b0;
      step();
      step();
      chk("rst busy", 32'(busy), 32'd1);
      chk("rst pred_d", 32'(pred_d), 32'd0);
      chk("rst pred_f", 32'(pred_f), 32'd0);
      chk_stats("rst");
      reset = 1'b1;

      // init walk after reset
      run_init(1'b0, cyc);
      chk("init busy cycles", cyc, 32'd64);
      chk("init pred_f forced 0", pf_bad, 32'd0);
      chk("run busy", 32'(busy), 32'd0);
      chk_tbl("init");

      // saturating counter at idx 16
      pc_f = 32'h40;
      step();
      for (int i = 0; i < 8; i++) begin
         update_en = vecs[i].upd; pc_src_d = vecs[i].taken; mispred_d = vecs[i].mis;
         if (vecs[i].upd) begin
            exp_br++;
            if (vecs[i].mis) exp_mis++;
         end
         step();
         chk($sformatf("vec%0d ctr", i), 32'(dut.bht[16]), 32'(vecs[i].exp_ctr));
         chk($sformatf("vec%0d pred_f", i), 32'(pred_f), 32'(vecs[i].exp_pf));
         chk($sformatf("vec%0d pred_d", i), 32'(pred_d), 32'(vecs[i].exp_pd));
      end
      update_en = 1'b0; mispred_d = 1'b0;
      chk_stats("vec");

      // stall holds pred_d; reset_d wins over stall_d
      pc_f = 32'h50;
      step();
      update_en = 1'b1; pc_src_d = 1'b1;
      exp_br++;
      step();
      update_en = 1'b0;
      pc_f = 32'h40;
      step();
      step();
      chk("pre-stall pred_d", 32'(pred_d), 32'd0);
      stall_d = 1'b1; pc_f = 32'h50;
      #1 chk("stall pred_f", 32'(pred_f), 32'd1);
      step();
      chk("stall pred_d 1", 32'(pred_d), 32'd0);
      step();
      chk("stall pred_d 2", 32'(pred_d), 32'd0);
      stall_d = 1'b0;
      step();
      chk("unstall pred_d", 32'(pred_d), 32'd1);
      stall_d = 1'b1; reset_d = 1'b1;
      step();
      chk("flush pred_d", 32'(pred_d), 32'd0);
      chk("flush idx_d", 32'(dut.idx_d), 32'd0);
      stall_d = 1'b0; reset_d = 1'b0;

      // same-cycle read/write of idx 5: no bypass
      pc_f = 32'h14;
      step();
      update_en = 1'b1; pc_src_d = 1'b1; mispred_d = 1'b1;
      exp_br++; exp_mis++;
      #1 chk("same-cycle pred_f old", 32'(pred_f), 32'd0);
      step();
      update_en = 1'b0; mispred_d = 1'b0;
      chk("same-cycle pred_f new", 32'(pred_f), 32'd1);
      chk("same-cycle ctr", 32'(dut.bht[5]), 32'd2);
      chk_stats("pre-clear");

      // clear_tbl in RUN with a dropped update during re-init
      pc_f = 32'h40;
      clear_tbl = 1'b1;
      step();
      clear_tbl = 1'b0;
      exp_br = 0; exp_mis = 0;
      chk("clear busy", 32'(busy), 32'd1);
      chk_stats("clear");
      run_init(1'b1, cyc);
      chk("reinit busy cycles", cyc, 32'd64);
      chk("reinit pred_f forced 0", pf_bad, 32'd0);
      chk("dropped update entry", 32'(dut.bht[16]), 32'd1);
      chk_stats("reinit");
      chk_tbl("reinit");

      // statistics: 10 updates, 3 mispredicted; then saturation of the 4-bit copy
      for (int i = 0; i < 10; i++) begin
         update_en = 1'b1; pc_src_d = i[0]; mispred_d = (i % 3 == 2);
         step();
      end
      exp_br = 10; exp_mis = 3;
      update_en = 1'b0; mispred_d = 1'b0;
      step();
      chk_stats("stats10");
      for (int i = 0; i < 20; i++) begin
         update_en = 1'b1; pc_src_d = 1'b0; mispred_d = 1'b1;
         step();
      end
      exp_br = 30; exp_mis = 23;
      update_en = 1'b0; mispred_d = 1'b0;
      step();
      chk_stats("stats30");

      // async reset in the middle of a re-init walk
      clear_tbl = 1'b1;
      step();
      clear_tbl = 1'b0;
      repeat (10) step();
      chk("mid-init idx advanced", 32'(dut.u_seq.init_idx), 32'd10);
      reset = 1'b0;
      #2;
      chk("async rst init_idx", 32'(dut.u_seq.init_idx), 32'd0);
      chk("async rst busy", 32'(busy), 32'd1);
      exp_br = 0; exp_mis = 0;
      chk_stats("async rst");
      reset = 1'b1;
      run_init(1'b0, cyc);
      chk("post-rst busy cycles", cyc, 32'd64);
      chk_tbl("post-rst");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/bht_predictor.md
Name: bht_predictor

Overview:
- Dynamic branch direction predictor for the 5-stage MIPS core.
- Holds a branch history table (BHT) of 2-bit saturating counters, indexed by fetch PC.
- Produces a prediction in F and pipelines it into D as pred_d for the core controller, which returns the resolved outcome through update_en/pc_src_d.
- Contains an init sequencer that walks the table after reset or on request, plus saturating branch/mispredict statistics counters.

Parameters:
- IDX_BITS, 6, log2 of BHT entries; index = pc[IDX_BITS+1:2].
- INIT_VAL, 2'b01, counter value written during init (weakly not-taken).
- STAT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- pc_f  in  32  fetch-stage PC.
- stall_d  in  1  hold the F->D prediction register.
- reset_d  in  1  flush the F->D prediction register (jump or mispredict).
- update_en  in  1  branch resolved in D this cycle.
- pc_src_d  in  1  resolved direction (1 = taken).
- mispred_d  in  1  resolved branch was mispredicted.
- clear_tbl  in  1  one-cycle pulse requesting table re-init.
- pred_f  out  1  F-stage prediction (1 = predict taken).
- pred_d  out  1  prediction registered into D.
- busy  out  1  init sequencer active.
- branch_cnt  out  STAT_W  resolved branches, saturating.
- mispred_cnt  out  STAT_W  mispredicted branches, saturating.

Behaviour:
- Reset (reset=0, async):
  - State <= INIT, init_idx <= 0.
  - pred_d, idx_d, branch_cnt, mispred_cnt <= 0; busy=1 on exit from reset.
  - BHT contents are undefined until INIT completes.
- FSM states:
  - INIT: each cycle writes INIT_VAL to entry init_idx, then increments init_idx. After writing entry 2^IDX_BITS-1, go to RUN; init takes exactly 2^IDX_BITS cycles. busy=1, pred_f forced 0, BHT updates ignored, stat counters frozen.
  - RUN: busy=0. clear_tbl=1 -> INIT with init_idx<=0 on the next edge; stat counters also clear to 0.
  - clear_tbl asserted during INIT restarts the walk at 0.
- Prediction:
  - In RUN, pred_f = bht[pc_f[IDX_BITS+1:2]][1], combinational.
- F->D register (pred_d, idx_d):
  - reset_d=1: pred_d<=0, idx_d<=0. reset_d wins over stall_d.
  - Else stall_d=1: hold.
  - Else capture pred_f and the current index.
- Update (RUN, update_en=1):
  - bht[idx_d] saturating: taken -> min(v+1, 3); not taken -> max(v-1, 0).
  - 3 stays 3 on taken; 0 stays 0 on not-taken.
- Same-cycle read/write of the same index: pred_f returns the pre-update value (no bypass). The write lands at the clock edge.
- Statistics:
  - branch_cnt += 1 on update_en in RUN.
  - mispred_cnt += 1 on update_en & mispred_d in RUN.
  - Both saturate at 2^STAT_W-1.
  - mispred_d without update_en is ignored.
- update_en during INIT is dropped: no table write, no count.
- Reset mid-INIT or mid-RUN restarts INIT from index 0.

Decomposition:
- Package bp_pkg:
  - typedef bht_ctr_t (logic [1:0]).
  - Constants SNT=0, WNT=1, WT=2, ST=3.
  - enum bp_state_t {INIT, RUN}.
  - Function sat_update(bht_ctr_t v, logic taken).
- Sub-module bht_init_seq: owns the FSM and init_idx, and emits the write-enable/address/data mux selection. The table array and stats stay in the top.

Test Plan:
- Reset release, IDX_BITS=6 -> busy=1 for exactly 64 cycles, then 0; pred_f=0 throughout; every entry reads 2'b01.
- RUN, pc_f=0x40 (idx 16): two taken updates -> counter 01->10->11; pred_f=1; a third taken update keeps 11. Then 4 not-taken updates -> 00 and stays 00; pred_f=0.
- stall_d=1 while pc_f changes to an index predicting 1 -> pred_d holds 0. reset_d=1 together with stall_d=1 -> pred_d=0 next cycle.
- update_en=1 at idx 5 (counter 01 -> 10) in the same cycle pc_f indexes 5 -> pred_f=0 that cycle, 1 the following cycle.
- 10 updates with mispred_d on 3 -> branch_cnt=10, mispred_cnt=3. With STAT_W=4, 20 mispredicts -> both counters stick at 15.
- clear_tbl pulse in RUN, plus update_en during the following INIT -> 64-cycle re-init; counters cleared to 0; the dropped update leaves its entry at 01. Async reset asserted mid-INIT -> init_idx restarts at 0.
